// File: rtl/i2s_rx_stereo_fifo.sv
// Stereo I2S / left-justified receiver: oversampled pin capture, L/R pairing FSM,
// and a small show-ahead FIFO carrying one stereo pair per entry.
module i2s_rx_stereo_fifo #(
   parameter int DATA_WIDTH = 24,
   parameter int MODE       = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          sck,
   input  logic                          ws,
   input  logic                          sd,
   output logic [DATA_WIDTH-1:0]         out_left,
   output logic [DATA_WIDTH-1:0]         out_right,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic                          frame_err,
   input  logic                          clear_err
);

   localparam int             AW        = $clog2(FIFO_DEPTH);
   localparam int             CW        = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0]  FULL_CNT  = CW'(DATA_WIDTH);
   localparam logic [CW-1:0]  TOP_BIT   = CW'(DATA_WIDTH - 1);
   localparam logic [AW:0]    DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);
   localparam bit             LJ        = (MODE == 1);

   typedef enum logic [1:0] {S_SYNC, S_LEFT, S_RIGHT} state_t;

   logic r_sck_m, r_sck_s, r_sck_d, r_ws_m, r_ws_s, r_sd_m, r_sd_s;
   logic r_ws_prev;
   logic [CW-1:0] r_cnt;
   logic [DATA_WIDTH-1:0] r_word, r_left, r_push_l, r_push_r;
   logic r_push, r_overflow, r_frame_err;
   state_t r_state, w_state_nxt;

   logic w_rise, w_bnd, w_add_old, w_short, w_latch_l, w_close_r;
   logic [CW-1:0] w_cnt_cur;
   logic [DATA_WIDTH-1:0] w_word_cur;

   always_ff @(posedge clk) begin
      if (rst) begin
         {r_sck_m, r_sck_s, r_sck_d} <= '0;
         {r_ws_m, r_ws_s, r_sd_m, r_sd_s} <= '0;
      end else begin
         r_sck_m <= sck;
         r_sck_s <= r_sck_m;
         r_sck_d <= r_sck_s;
         r_ws_m  <= ws;
         r_ws_s  <= r_ws_m;
         r_sd_m  <= sd;
         r_sd_s  <= r_sd_m;
      end
   end

   assign w_rise = r_sck_s & ~r_sck_d;
   assign w_bnd  = w_rise & (r_ws_s != r_ws_prev);
   // In I2S mode the boundary-edge bit still belongs to the slot being closed.
   assign w_add_old = w_rise & (~w_bnd | ~LJ);

   // Bits land left-aligned, so a short slot is already zero-padded in its LSBs.
   always_comb begin
      w_word_cur = r_word;
      w_cnt_cur  = r_cnt;
      if (w_add_old && (r_cnt < FULL_CNT)) begin
         w_word_cur = r_word | ({{(DATA_WIDTH-1){1'b0}}, r_sd_s} << (TOP_BIT - r_cnt));
         w_cnt_cur  = r_cnt + CW'(1);
      end
   end

   assign w_short = (w_cnt_cur < FULL_CNT);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ws_prev <= 1'b0;
         r_word    <= '0;
         r_cnt     <= '0;
      end else if (w_rise) begin
         r_ws_prev <= r_ws_s;
         if (w_bnd) begin
            r_word <= LJ ? {r_sd_s, {(DATA_WIDTH-1){1'b0}}} : '0;
            r_cnt  <= LJ ? CW'(1) : '0;
         end else begin
            r_word <= w_word_cur;
            r_cnt  <= w_cnt_cur;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_SYNC;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_bnd) begin
         case (r_state)
            S_SYNC:  if (!r_ws_s) w_state_nxt = S_LEFT;
            S_LEFT:  if (r_ws_s)  w_state_nxt = S_RIGHT;
            S_RIGHT: if (!r_ws_s) w_state_nxt = S_LEFT;
            default: w_state_nxt = S_SYNC;
         endcase
      end
   end

   always_comb begin
      w_latch_l = 1'b0;
      w_close_r = 1'b0;
      if (w_bnd) begin
         w_latch_l = (r_state == S_LEFT) &&  r_ws_s;
         w_close_r = (r_state == S_RIGHT) && !r_ws_s;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_left   <= '0;
         r_push   <= 1'b0;
         r_push_l <= '0;
         r_push_r <= '0;
      end else begin
         r_push <= w_close_r;
         if (w_latch_l) r_left <= w_word_cur;
         if (w_close_r) begin
            r_push_l <= r_left;
            r_push_r <= w_word_cur;
         end
      end
   end

   logic [DATA_WIDTH-1:0] r_mem_l [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] r_mem_r [FIFO_DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [AW:0]   r_count;
   logic w_full, w_pop, w_wr, w_ovf_evt;

   assign out_valid = (r_count != '0);
   assign w_full    = (r_count == DEPTH_CNT);
   assign w_pop     = out_valid & out_ready;
   // A pop in the same clk frees the slot, so a full FIFO still accepts the push.
   assign w_wr      = r_push & (~w_full | w_pop);
   assign w_ovf_evt = r_push & w_full & ~w_pop;

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem_l[r_wptr] <= r_push_l;
         r_mem_r[r_wptr] <= r_push_r;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr)  r_wptr <= r_wptr + AW'(1);
         if (w_pop) r_rptr <= r_rptr + AW'(1);
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // A new error event in the same clk as clear_err keeps the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         if (w_ovf_evt)      r_overflow <= 1'b1;
         else if (clear_err) r_overflow <= 1'b0;
         if ((w_latch_l | w_close_r) & w_short) r_frame_err <= 1'b1;
         else if (clear_err)                    r_frame_err <= 1'b0;
      end
   end

   assign out_left   = out_valid ? r_mem_l[r_rptr] : '0;
   assign out_right  = out_valid ? r_mem_r[r_rptr] : '0;
   assign fifo_count = r_count;
   assign overflow   = r_overflow;
   assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_i2s_rx_stereo_fifo.sv
// Bench for i2s_rx_stereo_fifo: one I2S-mode and one left-justified DUT share the serial pins;
// expected pairs come from a slot-segment model of the played bit stream.
module tb_i2s_rx_stereo_fifo;
   localparam int DW = 24;
   localparam int D  = 4;

   logic clk = 1'b0;
   logic rst, sck, ws, sd, out_ready, clear_err;
   logic [DW-1:0] l0, r0, l1, r1;
   logic v0, v1, ovf0, ovf1, fe0, fe1;
   logic [2:0] c0, c1;

   int checks, failures;
   bit lj_ws[$], lj_sd[$], q_ws[$], q_sd[$];
   logic [47:0] got0[$], got1[$], exp0[$], exp1[$], m_pairs[$];
   bit m_err, err0, err1;

   always #5 clk = ~clk;

   i2s_rx_stereo_fifo #(.DATA_WIDTH(DW), .MODE(0), .FIFO_DEPTH(D)) u_i2s (
      .clk(clk), .rst(rst), .sck(sck), .ws(ws), .sd(sd),
      .out_left(l0), .out_right(r0), .out_valid(v0), .out_ready(out_ready),
      .fifo_count(c0), .overflow(ovf0), .frame_err(fe0), .clear_err(clear_err));

   i2s_rx_stereo_fifo #(.DATA_WIDTH(DW), .MODE(1), .FIFO_DEPTH(D)) u_lj (
      .clk(clk), .rst(rst), .sck(sck), .ws(ws), .sd(sd),
      .out_left(l1), .out_right(r1), .out_valid(v1), .out_ready(out_ready),
      .fifo_count(c1), .overflow(ovf1), .frame_err(fe1), .clear_err(clear_err));

   always @(negedge clk) begin
      if (!rst && out_ready) begin
         if (v0) got0.push_back({l0, r0});
         if (v1) got1.push_back({l1, r1});
      end
   end

   task automatic clear_stream();
      lj_ws.delete(); lj_sd.delete();
   endtask

   // Stream is built left-justified; I2S playback delays sd by one bit clock.
   task automatic add_slot(input bit w, input int n, input logic [31:0] val);
      for (int k = 0; k < n; k++) begin
         lj_ws.push_back(w);
         lj_sd.push_back(val[n-1-k]);
      end
   endtask

   task automatic add_frame(input int n, input logic [31:0] lv, input logic [31:0] rv);
      add_slot(1'b0, n, lv);
      add_slot(1'b1, n, rv);
   endtask

   task automatic finalize(input int m);
      q_ws.delete(); q_sd.delete();
      for (int i = 0; i < lj_ws.size(); i++) begin
         q_ws.push_back(lj_ws[i]);
         q_sd.push_back(m == 1 ? lj_sd[i] : (i == 0 ? 1'b0 : lj_sd[i-1]));
      end
   endtask

   // One element per bit clock; pidx schedules a one-clk out_ready pulse after that rise.
   task automatic play(input int from, input int to, input int pidx);
      for (int i = from; i < to; i++) begin
         ws = q_ws[i];
         sd = q_sd[i];
         repeat (5) @(posedge clk);
         #1 sck = 1'b1;
         for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (i == pidx && c == 3) out_ready = 1'b1;
            if (i == pidx && c == 4) out_ready = 1'b0;
         end
         sck = 1'b0;
      end
      repeat (12) @(posedge clk);
      #1;
   endtask

   // Slots are runs of constant ws; a slot counts only once the next run starts.
   task automatic model(input int m, input int first);
      int st[$];
      int a, b, cnt, lo, hi;
      logic [DW-1:0] w, lw;
      bit have_l;
      m_pairs.delete(); m_err = 0; have_l = 0; lw = '0;
      st.push_back(first);
      for (int i = first + 1; i < q_ws.size(); i++)
         if (q_ws[i] != q_ws[i-1]) st.push_back(i);
      for (int s = 0; s + 1 < st.size(); s++) begin
         a = st[s]; b = st[s+1]; w = '0; cnt = 0;
         lo = (m == 1) ? a : a + 1;
         hi = (m == 1) ? b - 1 : b;
         for (int j = lo; j <= hi; j++) begin
            if (cnt < DW) w[DW-1-cnt] = q_sd[j];
            cnt++;
         end
         if (q_ws[a] == 1'b0 && s > 0) begin
            lw = w; have_l = 1; m_err |= (cnt < DW);
         end else if (q_ws[a] == 1'b1 && have_l) begin
            m_pairs.push_back({lw, w}); m_err |= (cnt < DW); have_l = 0;
         end
      end
   endtask

   task automatic expect_both(input int first);
      model(0, first); exp0 = m_pairs; err0 = m_err;
      model(1, first); exp1 = m_pairs; err1 = m_err;
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      got0.delete(); got1.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({l0, r0, v0, c0, ovf0, fe0} !== '0) begin
         failures++; $display("FAIL reset_i2s: got %h exp 0", {l0, r0, v0, c0, ovf0, fe0});
      end
      checks++;
      if ({l1, r1, v1, c1, ovf1, fe1} !== '0) begin
         failures++; $display("FAIL reset_lj: got %h exp 0", {l1, r1, v1, c1, ovf1, fe1});
      end
      rst = 1'b0;
   endtask

   task automatic test_i2s_basic();
      do_reset(); clear_stream();
      add_slot(1'b1, 4, 0); add_frame(32, 32'h12345600, 32'hABCDEF00); add_slot(1'b0, 4, 0);
      finalize(0); play(0, q_ws.size(), -1); expect_both(0);
      checks++;
      if (got0.size() != 1 || got0[0] !== 48'h123456ABCDEF) begin
         failures++; $display("FAIL i2s_pair: got n=%0d %h exp 123456abcdef", got0.size(), got0.size() ? got0[0] : 48'h0);
      end
      checks++;
      if (got1 != exp1) begin
         failures++; $display("FAIL i2s_stream_lj_dut: got n=%0d exp n=%0d", got1.size(), exp1.size());
      end
      checks++;
      if ({c0, ovf0, fe0} !== 5'b0) begin
         failures++; $display("FAIL i2s_idle: got count=%0d ovf=%b ferr=%b exp 0 0 0", c0, ovf0, fe0);
      end
   endtask

   task automatic test_lj_mode();
      do_reset(); clear_stream();
      add_slot(1'b1, 4, 0); add_frame(32, 32'h12345600, 32'hABCDEF00); add_slot(1'b0, 4, 0);
      finalize(1); play(0, q_ws.size(), -1); expect_both(0);
      checks++;
      if (got1.size() != 1 || got1[0] !== 48'h123456ABCDEF) begin
         failures++; $display("FAIL lj_pair: got n=%0d %h exp 123456abcdef", got1.size(), got1.size() ? got1[0] : 48'h0);
      end
      checks++;
      if (got0.size() != 1 || got0[0] !== 48'h2468AC579BDE || got0[0] !== exp0[0]) begin
         failures++; $display("FAIL lj_misaligned: got n=%0d %h exp 2468ac579bde", got0.size(), got0.size() ? got0[0] : 48'h0);
      end
   endtask

   task automatic test_reset_midframe();
      do_reset(); clear_stream();
      add_slot(1'b1, 4, 0);
      add_frame(32, $urandom, $urandom);
      for (int f = 0; f < 3; f++) add_frame(32, $urandom, $urandom);
      add_slot(1'b0, 4, 0);
      finalize(0);
      play(0, 52, -1);
      @(posedge clk); #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({v0, c0, v1, c1} !== '0 || got0.size() != 0 || got1.size() != 0) begin
         failures++; $display("FAIL midreset_state: got v=%b%b cnt=%0d/%0d n=%0d/%0d exp all 0", v0, v1, c0, c1, got0.size(), got1.size());
      end
      rst = 1'b0;
      play(52, q_ws.size(), -1); expect_both(52);
      checks++;
      if (got0 != exp0 || exp0.size() != 3) begin
         failures++; $display("FAIL midreset_i2s: got n=%0d exp n=%0d (3)", got0.size(), exp0.size());
      end
      checks++;
      if (got1 != exp1) begin
         failures++; $display("FAIL midreset_lj: got n=%0d exp n=%0d", got1.size(), exp1.size());
      end
   endtask

   task automatic test_overflow();
      do_reset(); clear_stream(); out_ready = 1'b0;
      add_slot(1'b1, 4, 0);
      for (int f = 0; f < 6; f++) add_frame(32, $urandom, $urandom);
      add_slot(1'b0, 4, 0);
      finalize(1); play(0, q_ws.size(), -1); expect_both(0);
      checks++;
      if (c0 !== 3'(D) || c1 !== 3'(D) || ovf0 !== (exp0.size() > D) || ovf1 !== (exp1.size() > D)) begin
         failures++; $display("FAIL ovf_full: got cnt=%0d/%0d ovf=%b%b exp cnt=%0d ovf=11", c0, c1, ovf0, ovf1, D);
      end
      checks++;
      if ({l0, r0} !== exp0[0] || {l1, r1} !== exp1[0]) begin
         failures++; $display("FAIL ovf_head: got %h/%h exp %h/%h", {l0, r0}, {l1, r1}, exp0[0], exp1[0]);
      end
      clear_err = 1'b1; @(posedge clk); #1 clear_err = 1'b0;
      checks++;
      if (ovf0 !== 1'b0 || ovf1 !== 1'b0) begin
         failures++; $display("FAIL ovf_clear: got %b%b exp 00", ovf0, ovf1);
      end
      out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (got0.size() != D || got1.size() != D || c0 !== 3'd0) begin
         failures++; $display("FAIL ovf_drain_n: got n=%0d/%0d cnt=%0d exp n=%0d cnt=0", got0.size(), got1.size(), c0, D);
      end
      for (int i = 0; i < D && i < got0.size() && i < got1.size(); i++) begin
         checks++;
         if (got0[i] !== exp0[i] || got1[i] !== exp1[i]) begin
            failures++; $display("FAIL ovf_order[%0d]: got %h/%h exp %h/%h", i, got0[i], got1[i], exp0[i], exp1[i]);
         end
      end
   endtask

   task automatic test_short_slot();
      do_reset(); clear_stream();
      add_slot(1'b1, 4, 0); add_frame(16, 32'h8001, $urandom); add_slot(1'b0, 4, 0);
      finalize(0); play(0, q_ws.size(), -1); expect_both(0);
      checks++;
      if (got0.size() != 1 || got0[0][47:24] !== 24'h800100 || fe0 !== 1'b1) begin
         failures++; $display("FAIL short_slot: got n=%0d left=%h ferr=%b exp left=800100 ferr=1", got0.size(), got0.size() ? got0[0][47:24] : 24'h0, fe0);
      end
      checks++;
      if (got0 != exp0 || got1 != exp1 || fe1 !== err1) begin
         failures++; $display("FAIL short_model: got n=%0d/%0d ferr_lj=%b exp n=%0d/%0d ferr_lj=%b", got0.size(), got1.size(), fe1, exp0.size(), exp1.size(), err1);
      end
      clear_err = 1'b1; @(posedge clk); #1 clear_err = 1'b0;
      checks++;
      if (fe0 !== 1'b0 || fe1 !== 1'b0) begin
         failures++; $display("FAIL short_clear: got %b%b exp 00", fe0, fe1);
      end
   endtask

   task automatic test_full_pushpop();
      int pidx;
      do_reset(); clear_stream(); out_ready = 1'b0;
      add_slot(1'b1, 4, 0);
      for (int f = 0; f < 5; f++) add_frame(32, $urandom, $urandom);
      pidx = lj_ws.size();
      add_slot(1'b0, 4, 0);
      finalize(0); play(0, q_ws.size(), pidx); expect_both(0);
      checks++;
      if (c0 !== 3'(D) || c1 !== 3'(D) || ovf0 !== 1'b0 || ovf1 !== 1'b0) begin
         failures++; $display("FAIL pushpop_full: got cnt=%0d/%0d ovf=%b%b exp cnt=%0d ovf=00", c0, c1, ovf0, ovf1, D);
      end
      out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (got0 != exp0 || exp0.size() != 5) begin
         failures++; $display("FAIL pushpop_order_i2s: got n=%0d exp n=%0d (5)", got0.size(), exp0.size());
      end
      checks++;
      if (got1 != exp1) begin
         failures++; $display("FAIL pushpop_order_lj: got n=%0d exp n=%0d", got1.size(), exp1.size());
      end
   endtask

   task automatic test_random();
      int m;
      for (int it = 0; it < 3; it++) begin
         do_reset(); clear_stream();
         m = $urandom_range(0, 1);
         add_slot(1'b1, $urandom_range(2, 6), $urandom);
         for (int f = 0; f < 4; f++) add_frame($urandom_range(16, 32), $urandom, $urandom);
         add_slot(1'b0, 4, 0);
         finalize(m); play(0, q_ws.size(), -1); expect_both(0);
         checks++;
         if (got0 != exp0 || fe0 !== err0) begin
            failures++; $display("FAIL random_i2s[%0d]: got n=%0d ferr=%b exp n=%0d ferr=%b", it, got0.size(), fe0, exp0.size(), err0);
         end
         checks++;
         if (got1 != exp1 || fe1 !== err1) begin
            failures++; $display("FAIL random_lj[%0d]: got n=%0d ferr=%b exp n=%0d ferr=%b", it, got1.size(), fe1, exp1.size(), err1);
         end
      end
   endtask

   initial begin
      rst = 1'b1; sck = 1'b0; ws = 1'b1; sd = 1'b0; out_ready = 1'b1; clear_err = 1'b0;
      checks = 0; failures = 0;
      test_reset();
      test_i2s_basic();
      test_lj_mode();
      test_reset_midframe();
      test_overflow();
      test_short_slot();
      test_full_pushpop();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
